// File: rtl/i2c_arb_pkg.sv
// Shared types and cycle-budget constants for the I2C transaction arbiter.
package i2c_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_START, S_SHIFT, S_ACK} arb_state_t;

  localparam int ADDR_CYCLES = 8;
  localparam int BYTE_CYCLES = 8;
  localparam int FIRST_SHIFT = ADDR_CYCLES + BYTE_CYCLES;
  localparam int CNT_W       = $clog2(FIRST_SHIFT + 1);
endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational one-hot winner select: round-robin from ptr+1, or lowest index
// when I2C_ARB_FIXED_PRIO_EN is defined.
module i2c_rr_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         winner
);
  always_comb begin
    winner = '0;
`ifdef I2C_ARB_FIXED_PRIO_EN
    // Scan high to low so the lowest active index is written last and wins.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner    = '0;
        winner[i] = 1'b1;
      end
    end
`else
    // Scan from farthest to nearest after ptr; nearest active one wins.
    for (int i = N_REQ; i >= 1; i--) begin
      int idx;
      idx = (int'(ptr) + i) % N_REQ;
      if (req[idx]) begin
        winner      = '0;
        winner[idx] = 1'b1;
      end
    end
`endif
  end
endmodule

// File: rtl/i2c_txn_arbiter.sv
// Arbitrates N_REQ clients onto one I2C byte controller and sequences start/data_in.
// Define I2C_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module i2c_txn_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int LEN_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*LEN_W-1:0]   req_len,
  input  logic [N_REQ*8-1:0]       req_data,
  output logic [N_REQ-1:0]         data_ready,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         done,
  output logic                     busy,
  output logic                     ctrl_start,
  output logic [7:0]               ctrl_data
);
  localparam int PTR_W = $clog2(N_REQ);

  arb_state_t                     state, state_nxt;
  logic [CNT_W-1:0]               cyc_cnt;
  logic [LEN_W-1:0]               bytes_left;
  logic [PTR_W-1:0]               own_idx, win_idx, rr_ptr;
  logic [N_REQ-1:0]               win;
  logic                           fin;
  logic [N_REQ-1:0][7:0]          req_bytes;
  logic [N_REQ-1:0][LEN_W-1:0]    req_lens;
  logic [LEN_W-1:0]               win_len;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign req_bytes[g] = req_data[g*8 +: 8];
    assign req_lens[g]  = req_len[g*LEN_W +: LEN_W];
  end

  i2c_rr_picker #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .winner (win)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < N_REQ; i++)
      if (win[i]) win_idx = PTR_W'(i);
  end

  assign win_len = req_lens[win_idx];

`ifdef I2C_ARB_FIXED_PRIO_EN
  assign rr_ptr = '0;
`else
  // Pointer starts at the last index so requester 0 is first after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        rr_ptr <= PTR_W'(N_REQ - 1);
    else if (state == S_IDLE && |req)  rr_ptr <= win_idx;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt        <= '0;
      own_idx    <= '0;
      cyc_cnt    <= '0;
      bytes_left <= '0;
    end else begin
      case (state)
        S_IDLE: if (|req) begin
          gnt        <= win;
          own_idx    <= win_idx;
          bytes_left <= (win_len == '0) ? '0 : win_len - LEN_W'(1);
        end
        S_START: cyc_cnt <= CNT_W'(FIRST_SHIFT);
        S_SHIFT: cyc_cnt <= cyc_cnt - CNT_W'(1);
        S_ACK: begin
          if (bytes_left != '0) begin
            bytes_left <= bytes_left - LEN_W'(1);
            cyc_cnt    <= CNT_W'(BYTE_CYCLES);
          end else begin
            gnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  // ctrl_start/fin depend only on registered state, so req never reaches outputs.
  always_comb begin
    state_nxt  = state;
    ctrl_start = 1'b0;
    fin        = 1'b0;
    case (state)
      S_IDLE:  if (|req) state_nxt = S_START;
      S_START: begin
        ctrl_start = 1'b1;
        state_nxt  = S_SHIFT;
      end
      S_SHIFT: if (cyc_cnt == CNT_W'(1)) state_nxt = S_ACK;
      S_ACK: begin
        if (bytes_left != '0) begin
          ctrl_start = 1'b1;
          state_nxt  = S_SHIFT;
        end else begin
          fin       = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy       = (state != S_IDLE);
  assign data_ready = ctrl_start ? gnt : '0;
  assign done       = fin ? gnt : '0;
  assign ctrl_data  = ctrl_start ? req_bytes[own_idx] : 8'h00;
endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Directed, table-driven bench for i2c_txn_arbiter (N_REQ=4, LEN_W=4).
module tb_i2c_txn_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] req_len;
  logic [31:0] req_data;
  logic [3:0]  data_ready, gnt, done;
  logic        busy, ctrl_start;
  logic [7:0]  ctrl_data;
  logic [7:0]  cur [4];
  int          n_cmp = 0;
  int          n_err = 0;

  typedef struct {
    logic [3:0] rq;
    int          drop_at;
    int          own;
    int          len;
  } vec_t;

  vec_t tbl [8];

  always #5 clk = ~clk;

  assign req_data = {cur[3], cur[2], cur[1], cur[0]};

  i2c_txn_arbiter #(.N_REQ(4), .LEN_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .req_len    (req_len),
    .req_data   (req_data),
    .data_ready (data_ready),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .ctrl_start (ctrl_start),
    .ctrl_data  (ctrl_data)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %06h expected %06h", nm, act, exp);
    end
  endtask

  // Output bundle {gnt, done, data_ready, busy, ctrl_start, ctrl_data}.
  function automatic logic [21:0] outs();
    return {gnt, done, data_ready, busy, ctrl_start, ctrl_data};
  endfunction

  // Called at a negedge of an IDLE cycle t; checks cycles t+1 .. t+D+1.
  task automatic run_txn(input int vi, input logic [3:0] rq, input int drop_at,
                         input int own, input int len);
    int          d;
    logic        st;
    logic [3:0]  oh;
    logic [21:0] exp;
    d   = 18 + 9 * (len - 1);
    oh  = 4'b0001 << own;
    req = rq;
    for (int c = 1; c <= d + 1; c++) begin
      @(negedge clk);
      st = (c == 1) || (c >= 18 && c < d && ((c - 18) % 9) == 0);
      if (c <= d)
        exp = {oh, (c == d) ? oh : 4'b0, st ? oh : 4'b0, 1'b1, st, st ? cur[own] : 8'h00};
      else
        exp = 22'h0;
      chk($sformatf("txn%0d cyc%0d", vi, c), {10'h0, outs()}, {10'h0, exp});
      if (st) cur[own] = cur[own] + 8'h11;
      if (c == drop_at) req = 4'b0000;
    end
  endtask

  initial begin
    logic [21:0] zero_outs;
    zero_outs = '0;
    rst_n   = 1'b0;
    req     = 4'b0000;
    req_len = {4'd0, 4'd2, 4'd3, 4'd1};
    cur[0] = 8'hA5; cur[1] = 8'h11; cur[2] = 8'h40; cur[3] = 8'h7E;

    tbl[0] = '{4'b0001, 1, 0, 1};
    tbl[1] = '{4'b0010, 1, 1, 3};
    tbl[2] = '{4'b1000, 1, 3, 1};
    tbl[3] = '{4'b0101, 0, 0, 1};
`ifdef I2C_ARB_FIXED_PRIO_EN
    tbl[4] = '{4'b0101, 0, 0, 1};
    tbl[5] = '{4'b0101, 0, 0, 1};
    tbl[6] = '{4'b0101, 1, 0, 1};
`else
    tbl[4] = '{4'b0101, 0, 2, 2};
    tbl[5] = '{4'b0101, 0, 0, 1};
    tbl[6] = '{4'b0101, 1, 2, 2};
`endif
    tbl[7] = '{4'b0001, 5, 0, 1};

    repeat (2) @(negedge clk);
    chk("reset_outs", {10'h0, outs()}, {10'h0, zero_outs});
    rst_n = 1'b1;
    chk("post_release_outs", {10'h0, outs()}, {10'h0, zero_outs});

    for (int v = 0; v < 8; v++)
      run_txn(v, tbl[v].rq, tbl[v].drop_at, tbl[v].own, tbl[v].len);

    // Reset in the middle of a burst owned by requester 0.
    req = 4'b0001;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) begin
        chk("mid_rst start", {31'h0, ctrl_start}, 32'h1);
        cur[0] = cur[0] + 8'h11;
        req = 4'b0000;
      end
    end
    chk("mid_rst busy_before", {31'h0, busy}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst outs", {10'h0, outs()}, {10'h0, zero_outs});
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("in_rst done_busy%0d", c), {27'h0, done, busy}, 32'h0);
    end
    rst_n = 1'b1;
    // Pointer must be back at N_REQ-1, so 0 beats 2.
    run_txn(8, 4'b0101, 1, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/i2c_txn_arbiter.md
# i2c_txn_arbiter

Shares the single I2C byte controller between `N_REQ` requesters and sequences its `start`/`data_in` pins. Picks one requester per transaction (round-robin), then feeds that requester's burst of 1..2^LEN_W−1 bytes. It tracks the controller's fixed cycle budget internally: 1 start cycle, 8 address cycles, then 8 data cycles and 1 ACK cycle per byte. It sits between the client blocks and the controller; the controller's `start`/`data_in` are driven only by this block.

## Interface
- `N_REQ`, 4, number of requesters (2..8)
- `LEN_W`, 4, width of per-requester burst length

- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `req`  in  N_REQ  transaction request per requester, level
- `req_len`  in  N_REQ*LEN_W  burst byte count per requester; 0 is treated as 1
- `req_data`  in  N_REQ*8  current byte per requester
- `data_ready`  out  N_REQ  one-cycle pulse: owner's `req_data` consumed this cycle
- `gnt`  out  N_REQ  one-hot owner, held for the whole transaction
- `done`  out  N_REQ  one-cycle pulse at the owner's final ACK cycle
- `busy`  out  1  high whenever the state is not S_IDLE
- `ctrl_start`  out  1  to controller `start`
- `ctrl_data`  out  8  to controller `data_in`

## Operation
- States: S_IDLE, S_START, S_SHIFT, S_ACK.
- **S_IDLE**
  - If any `req` bit is high, register the winner into `gnt` and load `bytes_left = max(req_len[w],1)−1`.
  - Then go to S_START.
- **S_START** (controller is in IDLE)
  - `ctrl_start=1`, `ctrl_data=req_data[owner]`, `data_ready[owner]=1`.
  - Load `cyc_cnt=16`, go to S_SHIFT.
- **S_SHIFT**
  - `ctrl_start=0`; decrement `cyc_cnt`.
  - When `cyc_cnt` reaches 1, go to S_ACK.
- **S_ACK** (controller is in ACK)
  - If `bytes_left>0`: `ctrl_start=1`, `ctrl_data=req_data[owner]`, `data_ready[owner]=1`, decrement `bytes_left`, `cyc_cnt=8`, go to S_SHIFT.
  - Otherwise: `done[owner]=1`, go to S_IDLE, clear `gnt`.
- Round-robin:
  - Search starts at last owner+1, wrapping.
  - Pointer resets to N_REQ−1, so requester 0 wins first.
  - Pointer updates only on a grant.
- `req` and `req_len` are sampled only in S_IDLE.
  - Dropping `req` mid-burst is ignored; the burst completes.
  - `req_len` changes after the grant are ignored.
- `ctrl_data` is 8'h00 whenever `ctrl_start=0`.
- `data_ready`, `done` and `ctrl_start` are Moore decodes of the registered state; no combinational path from `req` to any output.

## Timing
- Reset values: state S_IDLE, `gnt=0`, `done=0`, `data_ready=0`, `busy=0`, `ctrl_start=0`, `ctrl_data=0`, `cyc_cnt=0`, `bytes_left=0`, RR pointer N_REQ−1.
- With `req` first seen high in S_IDLE at cycle t:
  - S_START (start pulse) at t+1.
  - S_SHIFT from t+2 to t+17.
  - First S_ACK at t+18.
  - Each further byte: S_ACK at t+18+9k for k=1..L−1.
- Final `done` at t+18+9(L−1); S_IDLE at the next cycle.
- Back-to-back transactions:
  - At least one S_IDLE cycle separates them.
  - The controller has returned to IDLE by then.
- Reset asserted mid-operation:
  - Immediate return to reset values, with no `done` pulse.
  - The controller shares `rst_n` and also restarts.
- Simultaneous requests: exactly one grant; all others wait, with no starvation under round-robin.

## Configuration
- `I2C_ARB_FIXED_PRIO_EN`
  - Defined: fixed priority; the lowest-index active `req` always wins, and the RR pointer is not instantiated.
  - Undefined (default): round-robin as above.

## Structure
- Package `i2c_arb_pkg` holds:
  - `arb_state_t` enum.
  - `ADDR_CYCLES=8`, `BYTE_CYCLES=8`, `FIRST_SHIFT=ADDR_CYCLES+BYTE_CYCLES`.
- One sub-module, `i2c_rr_picker`:
  - Inputs: request vector, pointer. Output: one-hot winner.
  - Purely combinational; also implements fixed priority under the macro.

## Test plan
- req[0]=1, len=1, data=0xA5 at cycle t:
  - `ctrl_start` and `data_ready[0]` high only at t+1, with `ctrl_data=0xA5`.
  - `done[0]` at t+18; `busy` low at t+19.
- req[1] len=3, data 0x11/0x22/0x33 advanced on each `data_ready`:
  - Starts at t+1, t+18, t+27 with those bytes.
  - `done[1]` at t+36.
- req[0] and req[2] held high continuously:
  - Grants alternate 0,2,0,2 after reset.
  - With `I2C_ARB_FIXED_PRIO_EN` defined: grants are 0,0,0.
- `req_len[3]=0`: single byte transferred, `done[3]` at t+18.
- `rst_n` low at t+10 of a burst:
  - All outputs 0 within the same cycle, no `done`.
  - After release, requester 0 wins first.
- req[0] dropped at t+5: burst still completes, `done[0]` at t+18.
